// File: rtl/rtc_bus_sequencer_if.sv
// ============================================================================
// Module      : rtc_bus_sequencer_if
// Description : Handshake and RTC pin bundle between the read/write controller
//               and rtc_bus_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rtc_bus_sequencer_if;
    logic       start;
    logic       rw;
    logic [7:0] adr_in;
    logic [7:0] ADRESS;
    logic       BEnv_Adress;
    logic       BEnv_Data;
    logic       BRes_Data;
    logic       CS_n;
    logic       AD;
    logic       WR_n;
    logic       RD_n;
    logic       busy;
    logic       done;

    modport master (
        input  start, rw, adr_in,
        output ADRESS, BEnv_Adress, BEnv_Data, BRes_Data,
               CS_n, AD, WR_n, RD_n, busy, done
    );

    modport slave (
        output start, rw, adr_in,
        input  ADRESS, BEnv_Adress, BEnv_Data, BRes_Data,
               CS_n, AD, WR_n, RD_n, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
// ============================================================================
// Module      : rtc_bus_sequencer
// Description : Multiplexed address/data bus initiator for the RTC chip.
//               Optional turnaround cycle: define RTC_BUS_TURNAROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_sequencer #(
    parameter int T_LOW  = 4,
    parameter int T_HIGH = 4,
    parameter int T_GAP  = 2
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    rtc_bus_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADR_LOW  = 3'd1,
        S_ADR_HIGH = 3'd2,
        S_TURN     = 3'd3,
        S_DAT_LOW  = 3'd4,
        S_DAT_HIGH = 3'd5,
        S_DONE     = 3'd6,
        S_GAP      = 3'd7
    } state_t;

    localparam logic [7:0] LOW_LAST  = 8'(T_LOW - 1);
    localparam logic [7:0] HIGH_LAST = 8'(T_HIGH - 1);
    localparam logic [7:0] GAP_LAST  = (T_GAP == 0) ? 8'd0 : 8'(T_GAP - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic [7:0] adr_q, adr_d;

    logic cs_n_q, cs_n_d, ad_q, ad_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic benv_adr_q, benv_adr_d, benv_dat_q, benv_dat_d, bres_q, bres_d;
    logic busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        adr_d   = adr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rw_d    = bus.rw;
                    adr_d   = bus.adr_in;
                    state_d = S_ADR_LOW;
                end
            end
            S_ADR_LOW:  if (cnt_q == LOW_LAST) state_d = S_ADR_HIGH;
            S_ADR_HIGH: begin
                if (cnt_q == HIGH_LAST) begin
`ifdef RTC_BUS_TURNAROUND_EN
                    state_d = S_TURN;
`else
                    state_d = S_DAT_LOW;
`endif
                end
            end
            S_TURN:     state_d = S_DAT_LOW;
            S_DAT_LOW:  if (cnt_q == LOW_LAST) state_d = S_DAT_HIGH;
            S_DAT_HIGH: if (cnt_q == HIGH_LAST) state_d = S_DONE;
            S_DONE:     state_d = (T_GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:      if (cnt_q == GAP_LAST) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Phase counter restarts at zero on every state entry.
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they describe.
    always_comb begin
        cs_n_d     = 1'b1;
        ad_d       = 1'b1;
        wr_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        benv_adr_d = 1'b0;
        benv_dat_d = 1'b0;
        bres_d     = 1'b0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        case (state_d)
            S_ADR_LOW: begin
                cs_n_d     = 1'b0;
                ad_d       = 1'b0;
                wr_n_d     = 1'b0;
                benv_adr_d = 1'b1;
            end
            S_ADR_HIGH: begin
                ad_d       = 1'b0;
                benv_adr_d = 1'b1;
            end
            S_DAT_LOW: begin
                cs_n_d = 1'b0;
                if (rw_d) begin
                    rd_n_d = 1'b0;
                    bres_d = (cnt_d == LOW_LAST);
                end else begin
                    wr_n_d     = 1'b0;
                    benv_dat_d = 1'b1;
                end
            end
            S_DAT_HIGH: benv_dat_d = ~rw_d;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            rw_q       <= 1'b0;
            adr_q      <= 8'h00;
            cs_n_q     <= 1'b1;
            ad_q       <= 1'b1;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            benv_adr_q <= 1'b0;
            benv_dat_q <= 1'b0;
            bres_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            adr_q      <= adr_d;
            cs_n_q     <= cs_n_d;
            ad_q       <= ad_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            benv_adr_q <= benv_adr_d;
            benv_dat_q <= benv_dat_d;
            bres_q     <= bres_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.ADRESS      = adr_q;
    assign bus.CS_n        = cs_n_q;
    assign bus.AD          = ad_q;
    assign bus.WR_n        = wr_n_q;
    assign bus.RD_n        = rd_n_q;
    assign bus.BEnv_Adress = benv_adr_q;
    assign bus.BEnv_Data   = benv_dat_q;
    assign bus.BRes_Data   = bres_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

`default_nettype wire
